// File: rtl/pixel_stream_out.sv
// pixel_stream_out
//   Output stage of the ray tracing unit. Takes the unstallable per-pixel
//   strobe and RGB colour, tags each pixel with start-of-frame, end-of-line
//   and end-of-frame flags, and buffers it in a small FIFO. The FIFO drives
//   a registered, first-word-fall-through, valid/ready pixel stream.
//
//   Optional feature macro: PIXEL_STREAM_TEST_PATTERN_EN
//     When defined, the test_pattern input is added. While it is high, the
//     colour of each pixel is replaced by 8 vertical colour bars.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   in_valid              pixel strobe from the ray tracing unit
//   in_r/in_g/in_b        pixel colour
//   image_width/height    frame geometry (0 is treated as 1)
//   test_pattern          colour-bar override (only with the macro)
//   out_data              {8'h00, r, g, b}
//   out_valid/out_ready   stream handshake
//   out_sof/eol/eof       frame flags of the presented word
//   overflow              sticky: a pixel was dropped because the FIFO was full
//   fifo_level            stored entries, including the presented word
//   frame_count           frames completed at the input side
module pixel_stream_out #(
  parameter int FIFO_DEPTH = 16,
  parameter int DIM_W      = 13,
  parameter int FCNT_W     = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [7:0]                    in_r,
  input  logic [7:0]                    in_g,
  input  logic [7:0]                    in_b,
  input  logic [DIM_W-1:0]              image_width,
  input  logic [DIM_W-1:0]              image_height,
`ifdef PIXEL_STREAM_TEST_PATTERN_EN
  input  logic                          test_pattern,
`endif
  output logic [31:0]                   out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_sof,
  output logic                          out_eol,
  output logic                          out_eof,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [FCNT_W-1:0]             frame_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t             state_q;
  logic [DIM_W-1:0]   w_l_q, h_l_q, x_q, y_q;
  logic [FCNT_W-1:0]  frame_q;
  logic               overflow_q;

  // Dimensions used for the current pixel. In IDLE the freshly latched
  // value applies to the pixel arriving on the same cycle.
  logic [DIM_W-1:0]   w_in, h_in, w_eff, h_eff;
  logic               px_sof, px_eol, px_eof;
  logic [23:0]        px_rgb;

  assign w_in  = (image_width  == '0) ? DIM_W'(1) : image_width;
  assign h_in  = (image_height == '0) ? DIM_W'(1) : image_height;
  assign w_eff = (state_q == IDLE) ? w_in : w_l_q;
  assign h_eff = (state_q == IDLE) ? h_in : h_l_q;

  assign px_sof = (x_q == '0) && (y_q == '0);
  assign px_eol = (x_q == w_eff - DIM_W'(1));
  assign px_eof = px_eol && (y_q == h_eff - DIM_W'(1));

`ifdef PIXEL_STREAM_TEST_PATTERN_EN
  logic [DIM_W+2:0] bar_full;
  logic [2:0]       bar;
  assign bar_full = {x_q, 3'b000} / {3'b000, w_eff};
  assign bar      = (bar_full > (DIM_W+3)'(7)) ? 3'd7 : bar_full[2:0];
  // Bar order white..black is a 3-bit down-count over {g, r, b}.
  assign px_rgb   = test_pattern ? {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}}
                                 : {in_r, in_g, in_b};
`else
  assign px_rgb   = {in_r, in_g, in_b};
`endif

  // FIFO bookkeeping
  logic [26:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
  logic [LVL_W-1:0] count_q, count_d;
  logic [26:0]      head_q, wr_entry;
  logic             out_valid_q;
  logic             full, pop, push, bypass, load_head;

  assign wr_entry = {px_sof, px_eol, px_eof, px_rgb};
  assign full     = (count_q == LVL_W'(FIFO_DEPTH));
  assign pop      = out_valid_q && out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push     = in_valid && (!full || pop);
  assign count_d  = count_q + LVL_W'(push) - LVL_W'(pop);
  assign wr_ptr_d = wr_ptr_q + PTR_W'(push);
  assign rd_ptr_d = rd_ptr_q + PTR_W'(pop);
  // The new word goes straight to the output when nothing else remains.
  assign bypass    = ((count_q - LVL_W'(pop)) == '0);
  assign load_head = (!out_valid_q || pop) && (count_d != '0);

  // Input-side FSM, geometry counters and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      w_l_q      <= DIM_W'(1);
      h_l_q      <= DIM_W'(1);
      x_q        <= '0;
      y_q        <= '0;
      frame_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (state_q == IDLE) begin
        w_l_q <= w_in;
        h_l_q <= h_in;
      end
      if (in_valid) begin
        if (px_eol) begin
          x_q <= '0;
          if (px_eof) begin
            y_q     <= '0;
            frame_q <= frame_q + FCNT_W'(1);
          end else begin
            y_q <= y_q + DIM_W'(1);
          end
        end else begin
          x_q <= x_q + DIM_W'(1);
        end
        case (state_q)
          IDLE:    if (!px_eof) state_q <= ACTIVE;
          ACTIVE:  if (px_eof)  state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
        if (!push) overflow_q <= 1'b1;
      end
    end
  end

  // Storage array, written without reset so it can map to RAM
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  // Pointers, level and the registered output word
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      head_q      <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= (count_d != '0);
      if (load_head) head_q <= bypass ? wr_entry : mem_q[rd_ptr_d];
    end
  end

  assign out_data    = {8'h00, head_q[23:0]};
  assign out_sof     = head_q[26];
  assign out_eol     = head_q[25];
  assign out_eof     = head_q[24];
  assign out_valid   = out_valid_q;
  assign overflow    = overflow_q;
  assign fifo_level  = count_q;
  assign frame_count = frame_q;

endmodule

// File: tb/tb_pixel_stream_out.sv
module tb_pixel_stream_out;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_r = '0, in_g = '0, in_b = '0;
  logic [12:0] image_width = 13'd4, image_height = 13'd2;
`ifdef PIXEL_STREAM_TEST_PATTERN_EN
  logic        test_pattern = 1'b0;
`endif
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_sof, out_eol, out_eof, overflow;
  logic [4:0]  fifo_level;
  logic [15:0] frame_count;

  pixel_stream_out #(.FIFO_DEPTH(DEPTH), .DIM_W(13), .FCNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .image_width(image_width), .image_height(image_height),
`ifdef PIXEL_STREAM_TEST_PATTERN_EN
    .test_pattern(test_pattern),
`endif
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
    .overflow(overflow), .fifo_level(fifo_level), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: frame position as a flat pixel index
  logic [26:0] mq[$];
  logic        m_ovf = 1'b0;
  logic [15:0] m_frame = '0;
  int          m_p = 0, m_w = 1, m_h = 1;

  // Words observed leaving the DUT: {sof, eol, eof, rgb}
  logic [26:0] obs[$];

  function automatic logic [23:0] pix(input int i);
    logic [7:0] v;
    v = i[7:0];
    return {v, ~v, v ^ 8'h5A};
  endfunction

  function automatic logic [23:0] bar_colour(input int bar);
    case (bar)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_update();
    logic [26:0] tmp;
    logic        sof, eol, eof;
    logic [23:0] rgb;
    int          col;
    if (reset) begin
      mq.delete();
      m_ovf   = 1'b0;
      m_frame = '0;
      m_p     = 0;
    end else begin
      if (mq.size() > 0 && out_ready) tmp = mq.pop_front();
      if (in_valid) begin
        if (m_p == 0) begin
          m_w = (image_width  == 0) ? 1 : int'(image_width);
          m_h = (image_height == 0) ? 1 : int'(image_height);
        end
        col = m_p % m_w;
        sof = (m_p == 0);
        eol = (col == m_w - 1);
        eof = (m_p == m_w * m_h - 1);
        rgb = {in_r, in_g, in_b};
`ifdef PIXEL_STREAM_TEST_PATTERN_EN
        if (test_pattern) rgb = bar_colour((col * 8) / m_w);
`endif
        if (mq.size() < DEPTH) mq.push_back({sof, eol, eof, rgb});
        else m_ovf = 1'b1;
        if (eof) begin
          m_p = 0;
          m_frame = m_frame + 16'd1;
        end else begin
          m_p++;
        end
      end
    end
  endtask

  task automatic compare();
    chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("frame_count", 32'(frame_count), 32'(m_frame));
    if (mq.size() > 0) begin
      chk("out_data", out_data, {8'h00, mq[0][23:0]});
      chk("flags", 32'({out_sof, out_eol, out_eof}), 32'(mq[0][26:24]));
    end
  endtask

  task automatic cycle();
    if (out_valid && out_ready) begin
      obs.push_back({out_sof, out_eol, out_eof, out_data[23:0]});
      $display("word %0d data=%h sof=%b eol=%b eof=%b level=%0d",
               obs.size() - 1, out_data, out_sof, out_eol, out_eof, fifo_level);
    end
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
  endtask

  task automatic send(input int idx);
    in_valid = 1'b1;
    {in_r, in_g, in_b} = pix(idx);
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_flags", 32'({out_sof, out_eol, out_eof}), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    cycle();
    reset = 1'b0;
    obs.delete();
  endtask

  logic [2:0] t1_flags [8] = '{3'b100, 3'b000, 3'b000, 3'b010,
                               3'b000, 3'b000, 3'b000, 3'b011};

  initial begin
    // 4x2 frame, back-to-back, consumer always ready
    do_reset();
    image_width = 13'd4; image_height = 13'd2; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(i);
    idle(3);
    chk("t1_words", 32'(obs.size()), 32'd8);
    for (int k = 0; k < 8 && k < obs.size(); k++) begin
      chk("t1_flags", 32'(obs[k][26:24]), 32'(t1_flags[k]));
      chk("t1_data", 32'(obs[k][23:0]), 32'(pix(k)));
    end
    chk("t1_frame_count", 32'(frame_count), 32'd1);

    // Fill past capacity with the consumer stalled, then drain
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      send(i);
      if (i == 15) begin
        chk("t2_level_full", 32'(fifo_level), 32'd16);
        chk("t2_no_ovf_yet", 32'(overflow), 32'd0);
      end
      if (i == 16) chk("t2_ovf_17th", 32'(overflow), 32'd1);
    end
    out_ready = 1'b1;
    idle(20);
    chk("t2_words", 32'(obs.size()), 32'd16);
    for (int k = 0; k < 16 && k < obs.size(); k++)
      chk("t2_data", 32'(obs[k][23:0]), 32'(pix(k)));

    // Full FIFO with simultaneous push and pop
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(100 + i);
    out_ready = 1'b1;
    send(200);
    chk("t3_level", 32'(fifo_level), 32'd16);
    chk("t3_no_ovf", 32'(overflow), 32'd0);
    idle(20);
    chk("t3_words", 32'(obs.size()), 32'd17);
    if (obs.size() > 0) chk("t3_last", 32'(obs[obs.size()-1][23:0]), 32'(pix(200)));

    // Reset in the middle of a frame
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send(i);
    do_reset();
    for (int i = 0; i < 8; i++) send(50 + i);
    idle(3);
    chk("t4_words", 32'(obs.size()), 32'd8);
    if (obs.size() > 0) chk("t4_first_sof", 32'(obs[0][26]), 32'd1);
    chk("t4_frame_count", 32'(frame_count), 32'd1);

    // Zero dimensions behave as 1x1 frames
    do_reset();
    image_width = 13'd0; image_height = 13'd0;
    for (int i = 0; i < 3; i++) send(i);
    idle(3);
    chk("t5_words", 32'(obs.size()), 32'd3);
    for (int k = 0; k < obs.size(); k++)
      chk("t5_flags", 32'(obs[k][26:24]), 32'd7);
    chk("t5_frame_count", 32'(frame_count), 32'd3);

`ifdef PIXEL_STREAM_TEST_PATTERN_EN
    begin
      logic [31:0] bars [8] = '{32'h00FFFFFF, 32'h00FFFF00, 32'h0000FFFF, 32'h0000FF00,
                                32'h00FF00FF, 32'h00FF0000, 32'h000000FF, 32'h00000000};
      do_reset();
      image_width = 13'd8; image_height = 13'd1; test_pattern = 1'b1;
      for (int i = 0; i < 8; i++) send(37 * i + 3);
      test_pattern = 1'b0;
      idle(3);
      chk("tp_words", 32'(obs.size()), 32'd8);
      for (int k = 0; k < 8 && k < obs.size(); k++)
        chk("tp_data", {8'h00, obs[k][23:0]}, bars[k]);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_stream_out.md
Name: pixel_stream_out

Overview:
- Downstream stage of the ray tracing unit: consumes its per-pixel valid strobe and 8-bit RGB outputs and converts them into a backpressured pixel stream for the frame writer / video output.
- Tags each pixel with start-of-frame, end-of-line and end-of-frame flags from image_width/image_height.
- Buffers pixels in a small FIFO, because the ray tracing unit has no ready input and cannot be stalled.

Parameters:
- FIFO_DEPTH, 16, pixel FIFO entries; power of two, minimum 2.
- DIM_W, 13, width of the image dimension inputs and of the x/y counters.
- FCNT_W, 16, width of the frame counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  pixel strobe from the ray tracing unit (validRead)
- in_r / in_g / in_b  in  8 each  pixel colour
- image_width  in  DIM_W  pixels per line
- image_height  in  DIM_W  lines per frame
- out_data  out  32  {8'h00, r, g, b}
- out_valid  out  1  out_data and flags are valid
- out_ready  in  1  consumer accepts the word
- out_sof  out  1  first pixel of a frame
- out_eol  out  1  last pixel of a line
- out_eof  out  1  last pixel of a frame
- overflow  out  1  sticky: a pixel was dropped
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy
- frame_count  out  FCNT_W  frames completed at the input side

Behaviour:
- Clocking and reset: one clock domain, clk. Reset is synchronous and active-high, applied on the clk edge while reset=1.
- Reset values: out_valid=0, out_data=0, all flags 0, overflow=0, fifo_level=0, frame_count=0, x=y=0, FSM=IDLE. FIFO contents are discarded.
- Reset mid-frame: the partial frame is lost. The next in_valid after reset is treated as SOF.
- Input-side FSM:
  - IDLE: waiting for the first pixel of a frame. Width and height are latched into w_l/h_l on every cycle spent in IDLE. A value of 0 is latched as 1.
  - ACTIVE: dimensions frozen. Changes to image_width/height take effect only at the next frame.
  - IDLE->ACTIVE on in_valid, unless the pixel is also EOF (1x1 frame), in which case the FSM stays in IDLE.
  - ACTIVE->IDLE on the in_valid that is EOF.
- Pixel tagging, on every in_valid:
  - sof = (x==0 && y==0)
  - eol = (x==w_l-1)
  - eof = eol && (y==h_l-1)
  - The flags are computed with the dimensions latched for the current frame. On an IDLE cycle that is the value latched from the inputs on that cycle.
- Counter update, on every in_valid:
  - x increments; on eol, x returns to 0 and y increments.
  - On eof, y returns to 0 and frame_count increments, wrapping at 2^FCNT_W.
- FIFO:
  - Entry width 27: {sof, eol, eof, r, g, b}.
  - Write on in_valid when not full.
  - If in_valid arrives when full, the pixel is dropped and overflow is set until reset. The counters still advance so geometry stays aligned; the dropped pixel's flags are lost.
  - Read when out_valid && out_ready.
- Output: registered output stage, first-word-fall-through.
  - A pixel written into an empty FIFO with out_valid=0 appears on out_valid the next cycle (1-cycle latency).
  - AXI-style handshake: once out_valid=1, out_data and the flags hold stable until out_ready=1.
  - With out_ready held at 1 and continuous input, throughput is 1 pixel per cycle with no bubbles.
- Simultaneous push and pop:
  - Allowed when full: the pop frees a slot, so the write succeeds and there is no overflow.
  - Allowed when empty: passes through with 1-cycle latency; the level stays correct.
- fifo_level counts stored entries, including the word currently presented on the output.

Optional Feature:
- Macro: PIXEL_STREAM_TEST_PATTERN_EN.
- When defined:
  - Adds input port test_pattern (1 bit).
  - While test_pattern=1, the colour written into the FIFO is replaced by 8 vertical colour bars. Bar index = x*8/w_l using latched width; colours in order white, yellow, cyan, green, magenta, red, blue, black (components 8'hFF or 8'h00).
  - Tagging, counters and handshake are unchanged; in_valid still paces pixels.
- When undefined: no port, and in_r/in_g/in_b pass through unmodified.

Test Plan:
- Width=4, height=2, 8 back-to-back in_valid, out_ready=1:
  - 8 words out, each 1 cycle after its input.
  - sof on word 0 only; eol on words 3 and 7; eof on word 7.
  - frame_count 0->1.
- FIFO_DEPTH=16, out_ready=0, 20 pixels in:
  - fifo_level=16; overflow rises on the 17th pixel.
  - Release out_ready: exactly 16 words out, data matching pixels 0..15.
- FIFO full, in_valid and out_ready asserted in the same cycle:
  - No overflow; level stays 16; the new pixel is the last word out.
- Reset after pixel 5 of a 4x2 frame, then 8 pixels:
  - The first post-reset word carries sof.
  - frame_count=1 after the 8th pixel; outputs were 0 during reset.
- Width=0, height=0, 3 pixels:
  - Every word has sof/eol/eof = 1/1/1; frame_count=3.
- With PIXEL_STREAM_TEST_PATTERN_EN, width=8, test_pattern=1, one line:
  - out_data = 00FFFFFF, 00FFFF00, 0000FFFF, 0000FF00, 00FF00FF, 00FF0000, 000000FF, 00000000.
